// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared defaults, sample type, read-FSM states and the
//               bit-reversal helper for the FFT reorder buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int c_N     = 1024;
    localparam int c_NN    = 10;
    localparam int c_WIDTH = 16;

    // One complex sample as stored in the reorder RAM.
    typedef struct packed {
        logic [c_WIDTH-1:0] re;
        logic [c_WIDTH-1:0] im;
    } sample_t;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } rd_state_t;

    // Reverse the low nn bits of k; bits at and above nn are returned as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] k, input int nn);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < nn) begin
                r[nn-1-i] = k[i];
            end
        end
        return r;
    endfunction

endpackage : fft_pkg
`default_nettype wire

// File: rtl/fft_reorder_ram.sv
`default_nettype none
// ============================================================================
// Module      : fft_reorder_ram
// Description : Simple dual-port RAM, one write port and one synchronous
//               read port. The address MSB selects the ping-pong bank.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_reorder_ram
    import fft_pkg::*;
#(
    parameter int ADDR_W = c_NN + 1,
    parameter int DATA_W = 2 * c_WIDTH
)(
    input  logic              clock,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    // Write port.
    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Synchronous read port; data appears the cycle after the address.
    always_ff @(posedge clock) begin
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule : fft_reorder_ram
`default_nettype wire

// File: rtl/fft_bitrev_reorder.sv
`default_nettype none
// ============================================================================
// Module      : fft_bitrev_reorder
// Description : Ping-pong reorder buffer. Captures bit-reversed FFT frames
//               and replays them in natural bin order, gapless, no stall.
// Options     : FFT_REORDER_HALF_SPECTRUM_EN - replay only bins 0..N/2.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int N     = c_N,
    parameter int NN    = c_NN,
    parameter int WIDTH = c_WIDTH
)(
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im
);

    localparam logic [NN-1:0] c_LAST_WR = NN'(N - 1);
`ifdef FFT_REORDER_HALF_SPECTRUM_EN
    localparam logic [NN-1:0] c_LAST_RD = NN'(N / 2);
`else
    localparam logic [NN-1:0] c_LAST_RD = NN'(N - 1);
`endif

    logic [NN-1:0]      r_wcnt;
    logic               r_wbank;
    logic               r_rbank;
    logic [1:0]         r_full;
    logic [1:0]         r_busy;
    rd_state_t          r_state;
    rd_state_t          w_state_nxt;
    logic [NN-1:0]      r_rcnt;
    logic [NN-1:0]      w_raddr;
    logic [NN-1:0]      w_waddr;
    logic               w_rd_en;
    logic               w_rd_start;
    logic               w_rd_done;
    logic               w_frame_done;
    logic               r_rd_valid;
    logic [2*WIDTH-1:0] w_rdata;

    assign w_frame_done = di_en && (r_wcnt == c_LAST_WR);
    assign w_waddr      = NN'(bitrev(32'(r_wcnt), NN));

    fft_reorder_ram #(
        .ADDR_W (NN + 1),
        .DATA_W (2 * WIDTH)
    ) u_ram (
        .clock     (clock),
        .i_wr_en   (di_en),
        .i_wr_addr ({r_wbank, w_waddr}),
        .i_wr_data ({di_re, di_im}),
        .i_rd_en   (w_rd_en),
        .i_rd_addr ({r_rbank, w_raddr}),
        .o_rd_data (w_rdata)
    );

    // Write side: count accepted samples, flip bank at the end of each frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wcnt  <= '0;
            r_wbank <= 1'b0;
        end else if (di_en) begin
            if (w_frame_done) begin
                r_wcnt  <= '0;
                r_wbank <= ~r_wbank;
            end else begin
                r_wcnt  <= r_wcnt + NN'(1);
            end
        end
    end

    // Bank flags: release on burst end, mark full on frame end (set wins).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_full <= '0;
            r_busy <= '0;
        end else begin
            if (w_rd_done) begin
                r_full[r_rbank] <= 1'b0;
                r_busy[r_rbank] <= 1'b0;
            end
            if (w_rd_start) begin
                r_busy[r_rbank] <= 1'b1;
            end
            if (w_frame_done) begin
                r_full[r_wbank] <= 1'b1;
            end
        end
    end

    // Read FSM state, read address counter and read bank.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_rcnt  <= '0;
            r_rbank <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_rd_start) begin
                r_rcnt <= NN'(1);
            end else if (r_state == S_READ) begin
                r_rcnt <= r_rcnt + NN'(1);
            end
            if (w_rd_done) begin
                r_rbank <= ~r_rbank;
            end
        end
    end

    // Read FSM next state and RAM read strobes; address 0 issued from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_raddr     = r_rcnt;
        w_rd_start  = 1'b0;
        w_rd_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_full[r_rbank]) begin
                    w_rd_en     = 1'b1;
                    w_raddr     = '0;
                    w_rd_start  = 1'b1;
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                w_rd_en = 1'b1;
                if (r_rcnt == c_LAST_RD) begin
                    w_rd_done   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output register: valid follows the RAM read by one cycle, data zeroed when idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            do_en      <= 1'b0;
            do_re      <= '0;
            do_im      <= '0;
        end else begin
            r_rd_valid <= w_rd_en;
            do_en      <= r_rd_valid;
            do_re      <= r_rd_valid ? w_rdata[2*WIDTH-1:WIDTH] : '0;
            do_im      <= r_rd_valid ? w_rdata[WIDTH-1:0]       : '0;
        end
    end

endmodule : fft_bitrev_reorder
`default_nettype wire

// File: tb/tb_fft_bitrev_reorder.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_bitrev_reorder
// Description : Self-checking bench for fft_bitrev_reorder. Frames are
//               stored as arrays; expected output bin m is input sample
//               rev(m) of the same frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_bitrev_reorder;

    localparam int N     = 1024;
    localparam int NN    = 10;
    localparam int WIDTH = 16;
`ifdef FFT_REORDER_HALF_SPECTRUM_EN
    localparam int BURST = N / 2 + 1;
`else
    localparam int BURST = N;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             di_en = 1'b0;
    logic [WIDTH-1:0] di_re = '0;
    logic [WIDTH-1:0] di_im = '0;
    logic             do_en;
    logic [WIDTH-1:0] do_re;
    logic [WIDTH-1:0] do_im;

    fft_bitrev_reorder #(.N(N), .NN(NN), .WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .di_en (di_en),
        .di_re (di_re),
        .di_im (di_im),
        .do_en (do_en),
        .do_re (do_re),
        .do_im (do_im)
    );

    always #5 clock = ~clock;

    // Edges are numbered by the value edge_cnt holds just after them.
    int edge_cnt = 0;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] fr_re [4][N];
    logic [WIDTH-1:0] fr_im [4][N];
    int first_edge;
    int last_edge [4];

    int nb;
    int idle_bad;
    int b_start [8];
    int b_len   [8];
    int b_bad   [8];
    logic [WIDTH-1:0] cap_re1, cap_re2;

    // Bit reversal by repeated division: peel LSBs of m, push them in from the right.
    function automatic int rev(input int m);
        int r = 0;
        int x = m;
        for (int i = 0; i < NN; i++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    task automatic fill_frame(input int f, input bit ramp);
        for (int k = 0; k < N; k++) begin
            fr_re[f][k] = ramp ? WIDTH'(k)         : WIDTH'($urandom);
            fr_im[f][k] = ramp ? WIDTH'(N - 1 - k) : WIDTH'($urandom);
        end
    endtask

    // Drives nfr frames; each write is checked against the bank-free invariant.
    task automatic drive_frames(input int nfr, input bit gappy);
        for (int f = 0; f < nfr; f++) begin
            for (int k = 0; k < N; k++) begin
                @(negedge clock);
                checks++;
                if (dut.r_full[dut.r_wbank] || dut.r_busy[dut.r_wbank]) begin
                    errors++;
                    $display("FAIL bank_free: frame %0d sample %0d targets bank %0d full=%b busy=%b, required free",
                             f, k, dut.r_wbank, dut.r_full, dut.r_busy);
                end
                di_en = 1'b1;
                di_re = fr_re[f][k];
                di_im = fr_im[f][k];
                if (f == 0 && k == 0) first_edge = edge_cnt + 1;
                if (k == N - 1) last_edge[f] = edge_cnt + 1;
                if (gappy) begin
                    @(negedge clock);
                    di_en = 1'b0;
                    di_re = WIDTH'($urandom);
                    di_im = WIDTH'($urandom);
                end
            end
        end
        @(negedge clock);
        di_en = 1'b0;
        di_re = '0;
        di_im = '0;
    endtask

    // Splits the output stream into bursts of at most BURST words and scores each.
    task automatic collect(input int nexp, input int max_cyc);
        int len;
        bit inb;
        int idx;
        len = 0; inb = 1'b0; nb = 0; idle_bad = 0;
        cap_re1 = 'x; cap_re2 = 'x;
        for (int b = 0; b < 8; b++) begin
            b_start[b] = -1; b_len[b] = 0; b_bad[b] = 0;
        end
        for (int c = 0; c < max_cyc && nb < nexp; c++) begin
            @(negedge clock);
            if (do_en === 1'b1) begin
                if (!inb) begin
                    inb = 1'b1;
                    len = 0;
                    b_start[nb] = edge_cnt;
                end
                idx = rev(len);
                if (do_re !== fr_re[nb][idx] || do_im !== fr_im[nb][idx]) b_bad[nb]++;
                if (nb == 0 && len == 1) cap_re1 = do_re;
                if (nb == 0 && len == 2) cap_re2 = do_re;
                len++;
                if (len == BURST) begin
                    b_len[nb] = len;
                    nb++;
                    inb = 1'b0;
                end
            end else begin
                if (inb) begin
                    b_len[nb] = len;
                    nb++;
                    inb = 1'b0;
                end
                if (do_re !== '0 || do_im !== '0) idle_bad++;
            end
        end
        if (inb) begin
            b_len[nb] = len;
            nb++;
        end
    endtask

    task automatic check_bursts(input string name, input int nexp);
        checks++;
        if (nb !== nexp) begin
            errors++;
            $display("FAIL %s_count: got %0d bursts, required %0d", name, nb, nexp);
        end
        for (int b = 0; b < nexp; b++) begin
            checks++;
            if (b_len[b] !== BURST) begin
                errors++;
                $display("FAIL %s_len[%0d]: got %0d, required %0d", name, b, b_len[b], BURST);
            end
            checks++;
            if (b_bad[b] !== 0) begin
                errors++;
                $display("FAIL %s_data[%0d]: got %0d bad words, required 0", name, b, b_bad[b]);
            end
            checks++;
            if (b_start[b] !== last_edge[b] + 2) begin
                errors++;
                $display("FAIL %s_start[%0d]: got edge %0d, required %0d", name, b, b_start[b], last_edge[b] + 2);
            end
        end
        checks++;
        if (idle_bad !== 0) begin
            errors++;
            $display("FAIL %s_idle_zero: got %0d nonzero idle cycles, required 0", name, idle_bad);
        end
        @(negedge clock);
        checks++;
        if (do_en !== 1'b0) begin
            errors++;
            $display("FAIL %s_tail: do_en got %b after last burst, required 0", name, do_en);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (do_en !== 1'b0 || do_re !== '0 || do_im !== '0) bad++;
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (do_en !== 1'b0 || do_re !== '0 || do_im !== '0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_idle: got %0d non-idle cycles, required 0", bad);
        end
    endtask

    task automatic test_single_frame();
        fill_frame(0, 1'b1);
        fork
            drive_frames(1, 1'b0);
            collect(1, 4 * N);
        join
        checks++;
        if (b_start[0] - first_edge !== N + 1) begin
            errors++;
            $display("FAIL single_latency: got %0d, required %0d", b_start[0] - first_edge, N + 1);
        end
        checks++;
        if (cap_re1 !== WIDTH'(512)) begin
            errors++;
            $display("FAIL single_bin1: got %0d, required 512", cap_re1);
        end
        checks++;
        if (cap_re2 !== WIDTH'(256)) begin
            errors++;
            $display("FAIL single_bin2: got %0d, required 256", cap_re2);
        end
        check_bursts("single", 1);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) fill_frame(f, 1'b0);
        fork
            drive_frames(3, 1'b0);
            collect(3, 6 * N);
        join
`ifndef FFT_REORDER_HALF_SPECTRUM_EN
        checks++;
        if (b_start[2] - b_start[0] !== 2 * N) begin
            errors++;
            $display("FAIL b2b_contiguous: burst 2 offset got %0d, required %0d", b_start[2] - b_start[0], 2 * N);
        end
`endif
        checks++;
        if (b_start[1] - first_edge !== 2 * N + 1) begin
            errors++;
            $display("FAIL b2b_second_start: got %0d, required %0d", b_start[1] - first_edge, 2 * N + 1);
        end
        check_bursts("b2b", 3);
    endtask

    task automatic test_gappy();
        fill_frame(0, 1'b0);
        fork
            drive_frames(1, 1'b1);
            collect(1, 6 * N);
        join
        check_bursts("gappy", 1);
    endtask

    task automatic test_reset_mid_frame();
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            di_en = 1'b1;
            di_re = WIDTH'($urandom);
            di_im = WIDTH'($urandom);
        end
        @(negedge clock);
        di_en = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        fill_frame(0, 1'b0);
        fork
            drive_frames(1, 1'b0);
            collect(1, 4 * N);
        join
        checks++;
        if (b_start[0] - first_edge !== N + 1) begin
            errors++;
            $display("FAIL rstframe_latency: got %0d, required %0d", b_start[0] - first_edge, N + 1);
        end
        check_bursts("rstframe", 1);
    endtask

    task automatic test_reset_mid_burst();
        int seen = 0;
        int late = 0;
        fill_frame(0, 1'b0);
        fill_frame(1, 1'b0);
        fork
            drive_frames(2, 1'b0);
            begin
                for (int c = 0; c < 4 * N && seen < BURST - 1; c++) begin
                    @(negedge clock);
                    if (do_en === 1'b1) seen++;
                end
                checks++;
                if (seen !== BURST - 1) begin
                    errors++;
                    $display("FAIL rstburst_wait: saw %0d words, required %0d", seen, BURST - 1);
                end
                #2 reset = 1'b1;
                #1;
                checks++;
                if (do_en !== 1'b0 || do_re !== '0 || do_im !== '0) begin
                    errors++;
                    $display("FAIL rstburst_async: en=%b re=%0d im=%0d, required all 0", do_en, do_re, do_im);
                end
                @(negedge clock);
                reset = 1'b0;
                for (int c = 0; c < 3 * N; c++) begin
                    @(negedge clock);
                    if (do_en !== 1'b0) late++;
                end
                checks++;
                if (late !== 0) begin
                    errors++;
                    $display("FAIL rstburst_discard: got %0d do_en cycles after reset, required 0", late);
                end
            end
        join
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gappy();
        test_reset_mid_frame();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_fft_bitrev_reorder
`default_nettype wire
